// File: rtl/frame_tick_ctrl.sv
// frame_tick_ctrl: frame/step tick generator with run/pause/clear FSM.
// Each frame tick fires every DIV_PERIOD clocks while running; a step tick fires every N frames.
module frame_tick_ctrl #(
    parameter int unsigned DIV_PERIOD = 416667
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic [5:0]  frames_per_step,
    output logic        frame_tick,
    output logic        step_tick,
    output logic [15:0] frame_cnt,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10} state_t;
    localparam logic [18:0] LAST = 19'(DIV_PERIOD - 1);

    state_t      state_q, state_d;
    logic [18:0] presc_q, presc_d;
    logic [5:0]  step_q, step_d, n_q, n_d, eff_n;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_tick_q, frame_tick_d, step_tick_q, step_tick_d;
    logic        launch, count_en, wrap, step_wrap;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (start && !pause) ? RUN : IDLE;
            RUN:     state_d = pause ? PAUSED : RUN;
            PAUSED:  state_d = (start && !pause) ? RUN : PAUSED;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
        eff_n        = (frames_per_step == 6'd0) ? 6'd1 : frames_per_step;
        launch       = state_q == IDLE && start && !pause && !clear;
        count_en     = state_q == RUN && !pause && !clear;
        wrap         = count_en && presc_q == LAST;
        step_wrap    = wrap && step_q == n_q - 6'd1;
        presc_d      = clear || launch || wrap ? 19'd0 : count_en ? presc_q + 19'd1 : presc_q;
        step_d       = clear || step_wrap ? 6'd0 : wrap ? step_q + 6'd1 : step_q;
        frame_cnt_d  = clear ? 16'd0 : wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
        n_d          = launch || step_wrap ? eff_n : n_q;
        frame_tick_d = wrap;
        step_tick_d  = step_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            presc_q      <= 19'd0;
            step_q       <= 6'd0;
            n_q          <= 6'd1;
            frame_cnt_q  <= 16'd0;
            frame_tick_q <= 1'b0;
            step_tick_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            step_q       <= step_d;
            n_q          <= n_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
            step_tick_q  <= step_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
    assign step_tick  = step_tick_q;
    assign frame_cnt  = frame_cnt_q;
    assign state      = state_q;
endmodule

// File: tb/tb_frame_tick_ctrl.sv
// tb_frame_tick_ctrl: directed checks of frame_tick_ctrl with DIV_PERIOD=4.
module tb_frame_tick_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [5:0]  frames_per_step = 6'd3;
    logic        frame_tick, step_tick;
    logic [15:0] frame_cnt;
    logic [1:0]  state;
    int total = 0, bad = 0;

    frame_tick_ctrl #(.DIV_PERIOD(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear),
        .frames_per_step(frames_per_step), .frame_tick(frame_tick), .step_tick(step_tick),
        .frame_cnt(frame_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Run k_max edges from a fresh prescaler of 0, checking ticks each cycle.
    task automatic run_check(input string tag, input int k_max, input int step_every, input int cnt0);
        for (int k = 1; k <= k_max; k++) begin
            cyc(1);
            chk({tag, "_ft"}, 32'(frame_tick), 32'(k % 4 == 0));
            chk({tag, "_st"}, 32'(step_tick), 32'(k % 4 == 0 && (k / 4) % step_every == 0));
            chk({tag, "_cnt"}, 32'(frame_cnt), 32'(cnt0 + k / 4));
        end
    endtask

    initial begin
        cyc(2);
        chk("rst_state", 32'(state), 0);
        chk("rst_ft", 32'(frame_tick), 0);
        chk("rst_st", 32'(step_tick), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_hold", 32'(state), 0);
        // basic run, N=3
        start = 1'b1; cyc(1); start = 1'b0;
        chk("run_state", 32'(state), 1);
        run_check("run", 24, 3, 0);
        // pause at prescaler 2 for 10 cycles
        cyc(2);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("pause_state", 32'(state), 2);
            chk("pause_ft", 32'(frame_tick), 0);
            chk("pause_cnt", 32'(frame_cnt), 6);
        end
        pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        chk("resume_state", 32'(state), 1);
        cyc(1); chk("resume_ft1", 32'(frame_tick), 0);
        cyc(1); chk("resume_ft2", 32'(frame_tick), 1);
        chk("resume_cnt", 32'(frame_cnt), 7);
        // pause on the wrap edge
        cyc(3);
        chk("pre_wrap_ft", 32'(frame_tick), 0);
        pause = 1'b1; cyc(1);
        chk("wrap_pause_ft", 32'(frame_tick), 0);
        chk("wrap_pause_state", 32'(state), 2);
        cyc(2);
        chk("wrap_pause_cnt", 32'(frame_cnt), 7);
        pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        chk("wrap_resume_ft0", 32'(frame_tick), 0);
        cyc(1);
        chk("wrap_resume_ft", 32'(frame_tick), 1);
        chk("wrap_resume_cnt", 32'(frame_cnt), 8);
        cyc(1);
        chk("wrap_resume_ft_off", 32'(frame_tick), 0);
        // clear + pause together on a wrap edge
        cyc(2);
        clear = 1'b1; pause = 1'b1; cyc(1); clear = 1'b0; pause = 1'b0;
        chk("clr_state", 32'(state), 0);
        chk("clr_cnt", 32'(frame_cnt), 0);
        chk("clr_ft", 32'(frame_tick), 0);
        cyc(1);
        chk("clr_idle", 32'(state), 0);
        start = 1'b1; cyc(1); start = 1'b0;
        run_check("clr_run", 4, 3, 0);
        // frames_per_step=0, then change to 2 mid-step
        clear = 1'b1; cyc(1); clear = 1'b0;
        frames_per_step = 6'd0;
        start = 1'b1; cyc(1); start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (k == 9) frames_per_step = 6'd2;
            chk("n0_ft", 32'(frame_tick), 32'(k % 4 == 0));
            chk("n0_st", 32'(step_tick), 32'(k == 4 || k == 8 || k == 12 || k == 20));
        end
        chk("n0_cnt", 32'(frame_cnt), 5);
        // preload frame_cnt to 65535 while paused
        pause = 1'b1; cyc(1);
        force dut.frame_cnt_q = 16'hFFFF;
        cyc(1);
        release dut.frame_cnt_q;
        cyc(1);
        chk("preload_cnt", 32'(frame_cnt), 65535);
        pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        cyc(3);
        chk("wrap16_pre", 32'(frame_cnt), 65535);
        cyc(1);
        chk("wrap16_ft", 32'(frame_tick), 1);
        chk("wrap16_cnt", 32'(frame_cnt), 0);
        // async reset mid-RUN, off the clock edge
        cyc(4);
        chk("prerst_ft", 32'(frame_tick), 1);
        chk("prerst_cnt", 32'(frame_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_ft", 32'(frame_tick), 0);
        chk("arst_st", 32'(step_tick), 0);
        chk("arst_cnt", 32'(frame_cnt), 0);
        cyc(1); rst_n = 1'b1;
        cyc(3);
        chk("post_rst_idle", 32'(state), 0);
        chk("post_rst_ft", 32'(frame_tick), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_tick_ctrl.md
FRAME_TICK_CTRL -- requirements
Module: frame_tick_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_PERIOD, default 416667, meaning clk cycles per frame tick (25 MHz -> 60 Hz), legal range 2..524288.
REQ-002 The block SHALL have port clk  input  1  system clock, 25 MHz.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  level, sampled each clk: run/resume request.
REQ-005 The block SHALL have port pause  input  1  level, sampled each clk: pause request.
REQ-006 The block SHALL have port clear  input  1  level, sampled each clk: synchronous return to IDLE with all counters zeroed.
REQ-007 The block SHALL have port frames_per_step  input  6  frame ticks per step tick; 0 is treated as 1.
REQ-008 The block SHALL have port frame_tick  output  1  one-cycle pulse per frame period.
REQ-009 The block SHALL have port step_tick  output  1  one-cycle pulse every frames_per_step frame ticks.
REQ-010 The block SHALL have port frame_cnt  output  16  number of frame ticks since the last clear/reset.
REQ-011 The block SHALL have port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSED.
REQ-012 The block SHALL drive all outputs from registers.

Function
REQ-013 The FSM SHALL use three states, IDLE, RUN and PAUSED; encoding 11 is unreachable and SHALL recover to IDLE on the next clk.
REQ-014 Command priority on each clk edge SHALL be clear > pause > start.
REQ-015 The FSM SHALL make these transitions: clear from any state -> IDLE; IDLE + start -> RUN; RUN + pause -> PAUSED; PAUSED + start (pause low) -> RUN; all other cases hold state.
REQ-016 A 19-bit prescaler SHALL increment only on edges where the state is RUN and no clear or pause is sampled.
REQ-017 When the prescaler equals DIV_PERIOD-1 on such an edge, it SHALL wrap to 0 and frame_tick SHALL be high for the following cycle only.
REQ-018 The IDLE->RUN transition SHALL load the prescaler with 0, so the first frame_tick is high DIV_PERIOD cycles after state first reads RUN.
REQ-019 In PAUSED, the prescaler, step counter and frame_cnt SHALL hold; PAUSED->RUN SHALL resume from the held prescaler value with no lost or extra tick.
REQ-020 If pause is sampled on the edge where the prescaler would wrap, the block SHALL emit no frame_tick; the tick SHALL occur on the first counting edge after resume.
REQ-021 On each frame_tick edge, frame_cnt SHALL increment modulo 2^16 (65535 -> 0, with no flag).
REQ-022 A 6-bit step counter SHALL advance on each frame_tick edge.
REQ-023 When the step counter equals the effective N-1, it SHALL wrap to 0 and step_tick SHALL be high in the same cycle as that frame_tick.
REQ-024 The effective N (frames_per_step, 0 -> 1) SHALL be latched on IDLE->RUN and on each step wrap; changes at other times SHALL take effect at the next step boundary.
REQ-025 With effective N = 1, step_tick SHALL equal frame_tick.
REQ-026 clear SHALL zero the prescaler, step counter and frame_cnt, and force frame_tick and step_tick low in the next cycle.
REQ-027 clear SHALL win over a coincident prescaler wrap, so no tick is emitted.
REQ-028 start held in RUN and pause held in PAUSED SHALL have no effect.

Reset
REQ-029 Asserting rst_n low SHALL immediately, without waiting for clk, set state to IDLE, the prescaler, step counter and frame_cnt to 0, and frame_tick and step_tick to 0.
REQ-030 After rst_n deasserts, the block SHALL stay in IDLE until start is sampled high.
REQ-031 Reset asserted mid-RUN SHALL discard all progress; there is no resume after reset.

Verification (DIV_PERIOD=4 override)
REQ-032 Bench SHALL check: reset, then start pulsed for 1 cycle, frames_per_step=3 -> state=01; frame_tick every 4 cycles; step_tick on the 3rd, 6th, ... frame_tick; frame_cnt = 1, 2, 3, ...
REQ-033 Bench SHALL check: pause asserted when the prescaler is 2, held 10 cycles, then start -> state=10 while held; no ticks while paused; next frame_tick exactly 2 RUN cycles after resume.
REQ-034 Bench SHALL check: pause sampled on the wrap edge -> no frame_tick; after start, tick on the first counting edge; frame_cnt increments once.
REQ-035 Bench SHALL check: clear and pause asserted together in RUN -> state=00, frame_cnt=0, no tick; a later start gives the first tick 4 cycles after RUN.
REQ-036 Bench SHALL check: frames_per_step=0 -> step_tick coincides with every frame_tick; changing it to 2 mid-step takes effect only after the next step wrap.
REQ-037 Bench SHALL check: frame_cnt preloaded to 65535 via a forced run -> wraps to 0 on the next tick; rst_n pulsed low mid-RUN, off a clk edge -> all outputs 0 and state=00 immediately.
